// File: rtl/tx_frame_sequencer_pkg.sv
// tx_seq_pkg: shared FSM state type and SELECT line-mux encodings for the frame sequencer.
package tx_seq_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_IDLE  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;
endpackage

// File: rtl/tx_frame_sequencer_if.sv
// tx_frame_sequencer_if: payload request inputs and line-mux control outputs of the sequencer.
interface tx_frame_sequencer_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            SELECT;
    logic                  SER_DATA;
    logic                  PAR_BIT;
    logic                  BUSY;
    modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input SELECT, SER_DATA, PAR_BIT, BUSY);
    modport slave  (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output SELECT, SER_DATA, PAR_BIT, BUSY);
endinterface

// File: rtl/tx_frame_sequencer_parity_calc.sv
// parity_calc: registers payload parity (even, or odd when i_typ=1) on the load strobe.
module parity_calc #(parameter int DATA_WIDTH = 8) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_typ,
    output logic                  o_par
);
    logic r_par;
    always_ff @(posedge clk) begin
        if (rst) r_par <= 1'b0;
        else if (i_load) r_par <= ^i_data ^ i_typ;
    end
    assign o_par = r_par;
endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: drives SELECT/SER_DATA/PAR_BIT of a registered 4:1 line mux, LSB-first frames.
// Parity state and logic exist only when TXSEQ_PARITY_EN is defined.
module tx_frame_sequencer
    import tx_seq_pkg::*;
#(parameter int DATA_WIDTH = 8) (
    input  logic                 CLK,
    input  logic                 RST,
    tx_frame_sequencer_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [1:0]            r_select;
    logic                  r_busy;
    logic                  w_accept;
    logic                  w_last;
    state_t                w_after_data;
    assign w_accept = bus.DATA_VALID && (r_state == IDLE || r_state == STOP);
    assign w_last   = r_cnt == CW'(DATA_WIDTH - 1);
`ifdef TXSEQ_PARITY_EN
    logic r_par_en;
    always_ff @(posedge CLK) begin
        if (RST) r_par_en <= 1'b0;
        else if (w_accept) r_par_en <= bus.PAR_EN;
    end
    parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .clk(CLK), .rst(RST), .i_load(w_accept), .i_data(bus.P_DATA), .i_typ(bus.PAR_TYP), .o_par(bus.PAR_BIT)
    );
    assign w_after_data = r_par_en ? PARITY : STOP;
`else
    logic w_unused;
    assign w_unused     = bus.PAR_EN ^ bus.PAR_TYP;
    assign bus.PAR_BIT  = 1'b0;
    assign w_after_data = STOP;
`endif
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_select <= SEL_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_shift  <= '0;
        end else begin
            case (r_state)
                IDLE, STOP: begin
                    // STOP doubles as an accept point so back-to-back frames have no idle gap
                    r_state  <= w_accept ? START : IDLE;
                    r_select <= w_accept ? SEL_START : SEL_IDLE;
                    r_busy   <= w_accept;
                    r_cnt    <= '0;
                    if (w_accept) r_shift <= bus.P_DATA;
                end
                START: begin
                    r_state  <= DATA;
                    r_select <= SEL_DATA;
                end
                DATA: begin
                    r_shift  <= r_shift >> 1;
                    r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                    r_state  <= w_last ? w_after_data : DATA;
                    r_select <= !w_last ? SEL_DATA : (w_after_data == PARITY) ? SEL_PAR : SEL_IDLE;
                end
`ifdef TXSEQ_PARITY_EN
                PARITY: begin
                    r_state  <= STOP;
                    r_select <= SEL_IDLE;
                end
`endif
                default: begin
                    r_state  <= IDLE;
                    r_select <= SEL_IDLE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end
    assign bus.SELECT   = r_select;
    assign bus.BUSY     = r_busy;
    assign bus.SER_DATA = r_shift[0];
endmodule

// File: doc/tx_frame_sequencer.md
TX_FRAME_SEQUENCER -- requirements
Module: tx_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of payload bits per frame (range 5..9).
REQ-002 SHALL have port CLK  input  1  bit-rate clock; one serial bit per rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload, sampled on acceptance.
REQ-005 SHALL have port DATA_VALID  input  1  payload-present request.
REQ-006 SHALL have port PAR_EN  input  1  parity bit enable, sampled on acceptance.
REQ-007 SHALL have port PAR_TYP  input  1  parity type, 0=even, 1=odd, sampled on acceptance.
REQ-008 SHALL have port SELECT  output  2  select for the 4:1 registered line mux.
REQ-009 SHALL have port SER_DATA  output  1  current payload bit (mux data input).
REQ-010 SHALL have port PAR_BIT  output  1  computed parity bit (mux parity input).
REQ-011 SHALL have port BUSY  output  1  frame in progress.

Function
REQ-012 SELECT encoding SHALL be fixed: 00 start (line 0), 01 stop/idle (line 1), 10 SER_DATA, 11 PAR_BIT.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs Moore-decoded from registered state, counter and shift register; no combinational input-to-output path.
REQ-014 IDLE: SELECT=01, BUSY=0; DATA_VALID=1 accepts the frame: latch P_DATA, PAR_EN, PAR_TYP, compute PAR_BIT; next state START.
REQ-015 START: SELECT=00, BUSY=1, exactly one cycle; next state DATA.
REQ-016 DATA: SELECT=10, BUSY=1, DATA_WIDTH cycles, LSB first; SER_DATA=shift-register bit 0, shifted right each cycle; 0-based bit counter of width clog2(DATA_WIDTH); leave when counter = DATA_WIDTH-1.
REQ-017 After DATA: next state PARITY if latched PAR_EN=1, else STOP.
REQ-018 PARITY: SELECT=11, BUSY=1, one cycle; PAR_BIT = XOR of latched payload, inverted when latched PAR_TYP=1.
REQ-019 STOP: SELECT=01, BUSY=1, one cycle; if DATA_VALID=1, accept a new frame per REQ-014 and go to START (back-to-back, no idle gap); else go to IDLE.
REQ-020 DATA_VALID in START, DATA or PARITY SHALL be ignored; P_DATA/PAR_EN/PAR_TYP changes mid-frame SHALL NOT affect the current frame.
REQ-021 Frame length SHALL be 2+DATA_WIDTH+PAR_EN cycles from START to STOP inclusive; the serial line lags SELECT by one cycle through the registered mux.
REQ-022 PAR_BIT SHALL hold its value until the next acceptance.

Reset
REQ-023 RST=1 at a rising edge SHALL force IDLE, SELECT=01, SER_DATA=0, PAR_BIT=0, BUSY=0, counter and shift register 0, from any state including mid-frame.
REQ-024 While RST=1, DATA_VALID SHALL NOT be accepted; the first acceptance is possible on the first edge with RST=0.

Configuration
REQ-025 Macro TXSEQ_PARITY_EN defined: PARITY state, parity computation and REQ-017/018 present.
REQ-026 Macro TXSEQ_PARITY_EN undefined: PARITY state and parity logic removed, PAR_EN/PAR_TYP present but ignored, PAR_BIT tied 0, DATA always goes to STOP, frame length 2+DATA_WIDTH.

Structure
REQ-027 Shared package tx_seq_pkg SHALL hold the state enumeration and the four SELECT encoding constants, imported by this block and by the line mux instance owner.
REQ-028 Parity computation SHALL be a separate sub-module parity_calc (P_DATA, PAR_TYP in, PAR_BIT out, register on load strobe), instantiated only under TXSEQ_PARITY_EN.

Verification
REQ-029 P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> SELECT sequence 00, 10x8, 01; SER_DATA 1,0,1,0,0,1,0,1; BUSY high 10 cycles.
REQ-030 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> 11-cycle frame, PAR_BIT=0; repeat with PAR_TYP=1 -> PAR_BIT=1.
REQ-031 DATA_VALID held high with 0x3C then 0xC3 presented in STOP -> second START immediately follows STOP, BUSY never drops, 20 consecutive busy cycles (PAR_EN=0).
REQ-032 RST=1 asserted on DATA bit index 3 -> next cycle SELECT=01, BUSY=0, state IDLE; new frame 0x0F after release completes correctly.
REQ-033 DATA_VALID pulsed with P_DATA=0xFF during DATA of a 0x00 frame -> pulse ignored, all SER_DATA=0, returns to IDLE after STOP.
REQ-034 Build without TXSEQ_PARITY_EN, PAR_EN=1, P_DATA=0x01 -> 10-cycle frame, SELECT never 11, PAR_BIT=0.
